// File: rtl/bf_code_loader_if.sv
// Loader-side bus: byte stream in, code RAM write port and core control out.
interface bf_code_loader_if #(
  parameter int addrSize_code = 9
);
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     core_done;
  logic [addrSize_code-1:0] code_addr;
  logic [7:0]               code_wdata;
  logic                     code_we;
  logic                     code_sel;
  logic                     core_reset;
  logic                     loading;
  logic                     error;
  logic [addrSize_code-1:0] prog_len;

  modport master (
    input  rx_valid, rx_data, core_done,
    output code_addr, code_wdata, code_we, code_sel, core_reset,
           loading, error, prog_len
  );

  modport slave (
    output rx_valid, rx_data, core_done,
    input  code_addr, code_wdata, code_we, code_sel, core_reset,
           loading, error, prog_len
  );
endinterface

// File: rtl/bf_code_loader.sv
// Streams a Brainfuck program from a byte source into code RAM, stripping comments and
// checking bracket balance, then releases the core and waits for it to finish.
module bf_code_loader #(
  parameter int addrSize_code = 9
) (
  input logic               clk,
  input logic               reset,
  bf_code_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [addrSize_code-1:0] PTR_MAX = '1;
  localparam logic [7:0] CH_ABORT = 8'h1B;
  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;

  state_t                   state, state_nxt;
  logic [addrSize_code-1:0] wr_ptr, ptr_nxt;
  logic [addrSize_code-1:0] depth, depth_nxt;
  logic [addrSize_code-1:0] addr_q, addr_nxt;
  logic [7:0]               wdata_q, wdata_nxt;
  logic                     we_q, we_nxt;
  logic                     core_reset_q, core_reset_nxt;
  logic                     code_sel_q, loading_q, error_q;

  logic                     take;
  logic [addrSize_code-1:0] base_ptr, base_depth;
  logic                     is_prog, is_term, is_abort;

  always_comb begin
    is_prog = 1'b0;
    case (bus.rx_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_prog = 1'b1;
      default: is_prog = 1'b0;
    endcase
  end

  assign is_term  = (bus.rx_data == 8'h00) || (bus.rx_data == 8'h04);
  assign is_abort = (bus.rx_data == CH_ABORT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_LOAD;
      wr_ptr       <= '0;
      depth        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b0;
      code_sel_q   <= 1'b1;
      loading_q    <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_ptr       <= ptr_nxt;
      depth        <= depth_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      we_q         <= we_nxt;
      core_reset_q <= core_reset_nxt;
      code_sel_q   <= !core_reset_nxt;
      loading_q    <= (state_nxt == S_LOAD);
      error_q      <= (state_nxt == S_ERROR);
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = wr_ptr;
    depth_nxt  = depth;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    we_nxt     = 1'b0;
    take       = 1'b0;
    base_ptr   = wr_ptr;
    base_depth = depth;

    case (state)
      S_LOAD:  take = bus.rx_valid;
      S_START: state_nxt = S_RUN;
      S_RUN:   if (bus.core_done) state_nxt = S_DONE;
      S_DONE: begin
        // A new byte starts a fresh load and is itself the first byte of it.
        if (bus.rx_valid) begin
          take       = 1'b1;
          base_ptr   = '0;
          base_depth = '0;
          ptr_nxt    = '0;
          depth_nxt  = '0;
          state_nxt  = S_LOAD;
        end
      end
      S_ERROR: begin
        if (bus.rx_valid && is_abort) begin
          ptr_nxt   = '0;
          depth_nxt = '0;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase

    if (take) begin
      if (is_abort) begin
        ptr_nxt   = '0;
        depth_nxt = '0;
        state_nxt = S_LOAD;
      end else if (is_term) begin
        if (base_depth != '0) begin
          state_nxt = S_ERROR;
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = base_ptr;
          wdata_nxt = 8'h00;
          state_nxt = S_START;
        end
      end else if (is_prog) begin
        // The final RAM slot is kept for the null terminator.
        if ((base_ptr == PTR_MAX) || ((bus.rx_data == CH_CLOSE) && (base_depth == '0))) begin
          state_nxt = S_ERROR;
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = base_ptr;
          wdata_nxt = bus.rx_data;
          ptr_nxt   = base_ptr + 1'b1;
          if (bus.rx_data == CH_OPEN) begin
            depth_nxt = base_depth + 1'b1;
          end else if (bus.rx_data == CH_CLOSE) begin
            depth_nxt = base_depth - 1'b1;
          end
        end
      end
    end

    // Rises only after a full cycle in RUN so the core sees a settled program; drops immediately.
    core_reset_nxt = ((state == S_RUN) || (state == S_DONE)) &&
                     ((state_nxt == S_RUN) || (state_nxt == S_DONE));
  end

  assign bus.code_addr  = addr_q;
  assign bus.code_wdata = wdata_q;
  assign bus.code_we    = we_q;
  assign bus.code_sel   = code_sel_q;
  assign bus.core_reset = core_reset_q;
  assign bus.loading    = loading_q;
  assign bus.error      = error_q;
  assign bus.prog_len   = wr_ptr;

endmodule
